// File: rtl/wb_pkg.sv
// wb_pkg: shared register-address/data widths, writeback queue entry and FSM state types.
package wb_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int DATA_W = 16;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_ERROR} wb_state_e;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: in-order circular write buffer with dual push (a older than b), single pop,
// and a youngest-match forwarding search over occupied entries.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_a,
    input  wb_entry_t             entry_a,
    input  logic                  push_b,
    input  wb_entry_t             entry_b,
    input  logic                  pop,
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    output wb_entry_t             head,
    output wb_entry_t             next_head,
    output logic [CW-1:0]         count,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data
);
    wb_entry_t buf_q [DEPTH];
    logic [PW-1:0] head_q, tail_q, idx;
    logic [CW-1:0] count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(push_a) + PW'(push_b);
            count_q <= count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end
    // Payload storage needs no reset: only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (push_a) buf_q[tail_q] <= entry_a;
        if (push_b) buf_q[push_a ? tail_q + PW'(1) : tail_q] <= entry_b;
    end
    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && buf_q[idx].dest == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_q[idx].data;
            end
        end
    end
    assign head      = buf_q[head_q];
    assign next_head = buf_q[head_q + PW'(1)];
    assign count     = count_q;
endmodule

// File: rtl/wb_write_ctrl.sv
// wb_write_ctrl: queues execute/load results and commits them one at a time to the
// regfile write port, retrying unconfirmed writes up to MAX_RETRY issues.
module wb_write_ctrl
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MAX_RETRY = 3,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int RW = $clog2(MAX_RETRY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic [DATA_W-1:0]     ex_data,
    output logic                  ex_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  mem_ready,
    output logic                  wr,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [DATA_W-1:0]     data_out,
    input  logic                  wr_success,
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CW-1:0]         pending,
    output logic                  wr_err
);
    wb_state_e state_q, state_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic wr_q, wr_d, pop, push_mem, push_ex, live;
    wb_entry_t out_q, out_d, head, next_head, issue_entry;
    logic [CW-1:0] count;
    assign live      = state_q != S_ERROR;
    assign mem_ready = live && count < CW'(DEPTH);
    assign ex_ready  = live && (mem_valid ? count <= CW'(DEPTH - 2) : count < CW'(DEPTH));
    assign push_mem  = mem_valid && mem_ready;
    assign push_ex   = ex_valid && ex_ready;
    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push_a    (push_mem),
        .entry_a   ('{dest: mem_dest, data: mem_data}),
        .push_b    (push_ex),
        .entry_b   ('{dest: ex_dest, data: ex_data}),
        .pop       (pop),
        .fwd_addr  (fwd_addr),
        .head      (head),
        .next_head (next_head),
        .count     (count),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );
    assign retry_inc = retry_q + RW'(1);
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        pop         = 1'b0;
        issue_entry = head;
        case (state_q)
            S_IDLE:     state_d = count != '0 ? S_ISSUE : S_IDLE;
            S_ISSUE:    state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (wr_success) begin
                    pop         = 1'b1;
                    retry_d     = '0;
                    issue_entry = next_head;
                    state_d     = count > CW'(1) ? S_ISSUE : S_IDLE;
                end else begin
                    retry_d = retry_inc;
                    state_d = retry_inc == RW'(MAX_RETRY) ? S_ERROR : S_ISSUE;
                end
            end
            default:    state_d = S_ERROR;
        endcase
        // The write strobe is registered, so it is raised on entry to ISSUE.
        wr_d  = state_d == S_ISSUE;
        out_d = wr_d ? issue_entry : out_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            retry_q <= '0;
            wr_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            wr_q    <= wr_d;
            out_q   <= out_d;
        end
    end
    assign wr       = wr_q;
    assign dest_out = out_q.dest;
    assign data_out = out_q.data;
    assign pending  = count;
    assign wr_err   = state_q == S_ERROR;
endmodule

// File: tb/tb_wb_write_ctrl.sv
// tb_wb_write_ctrl: directed vectors against hand-computed commit order, readiness and forwarding.
module tb_wb_write_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic ex_valid = 1'b0, mem_valid = 1'b0, wr_success = 1'b0;
    logic [2:0] ex_dest = '0, mem_dest = '0, fwd_addr = '0;
    logic [15:0] ex_data = '0, mem_data = '0;
    logic ex_ready, mem_ready, wr, fwd_hit, wr_err;
    logic [2:0] dest_out, pending;
    logic [15:0] data_out, fwd_data;
    int n_chk = 0, n_fail = 0;

    wb_write_ctrl #(.DEPTH(4), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_data(ex_data), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
        .wr(wr), .dest_out(dest_out), .data_out(data_out), .wr_success(wr_success),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .pending(pending), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit m, input logic [2:0] md, input logic [15:0] mv,
                        input bit e, input logic [2:0] ed, input logic [15:0] ev);
        mem_valid = m; mem_dest = md; mem_data = mv;
        ex_valid = e; ex_dest = ed; ex_data = ev;
        tick();
        mem_valid = 1'b0;
        ex_valid = 1'b0;
    endtask

    // Entered just after the edge that put the FSM in ISSUE.
    task automatic issue_ack(input string tag, input logic [2:0] d, input logic [15:0] v, input bit ack);
        chk({tag, "_wr"}, wr, 1);
        chk({tag, "_dest"}, dest_out, d);
        chk({tag, "_data"}, data_out, v);
        tick();
        chk({tag, "_wr_one_cycle"}, wr, 0);
        wr_success = ack;
        tick();
        wr_success = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_wr", wr, 0);
        chk("rst_pending", pending, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_dest", dest_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_rdy", {ex_ready, mem_ready}, 2'b11);
        tick();
        rst = 1'b0;
        tick();

        // single ex write
        ex_valid = 1'b1; ex_dest = 3'd3; ex_data = 16'hBEEF;
        #1 chk("t1_ex_ready", ex_ready, 1);
        tick();
        ex_valid = 1'b0;
        fwd_addr = 3'd3;
        #1;
        chk("t1_pending1", pending, 1);
        chk("t1_wr_early", wr, 0);
        chk("t1_fwd", {fwd_hit, fwd_data}, {1'b1, 16'hBEEF});
        tick();
        issue_ack("t1", 3'd3, 16'hBEEF, 1'b1);
        chk("t1_pending0", pending, 0);
        chk("t1_fwd_clear", {fwd_hit, fwd_data}, 17'h0);

        // dual push, mem older
        mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 16'h1111;
        ex_valid = 1'b1; ex_dest = 3'd1; ex_data = 16'h2222;
        fwd_addr = 3'd1;
        #1 chk("t2_rdy", {ex_ready, mem_ready}, 2'b11);
        tick();
        mem_valid = 1'b0; ex_valid = 1'b0;
        #1;
        chk("t2_pending", pending, 2);
        chk("t2_fwd_young", {fwd_hit, fwd_data}, {1'b1, 16'h2222});
        tick();
        issue_ack("t2a", 3'd1, 16'h1111, 1'b1);
        chk("t2_fwd_mid", {fwd_hit, fwd_data}, {1'b1, 16'h2222});
        chk("t2_pending_mid", pending, 1);
        issue_ack("t2b", 3'd1, 16'h2222, 1'b1);
        chk("t2_fwd_gone", fwd_hit, 0);
        chk("t2_pending0", pending, 0);

        // fill to DEPTH
        push(1'b1, 3'd2, 16'hA001, 1'b1, 3'd3, 16'hA002);
        mem_valid = 1'b1; mem_dest = 3'd4; mem_data = 16'hA003;
        ex_valid = 1'b1; ex_dest = 3'd5; ex_data = 16'hA004;
        #1 chk("t3_rdy_at2", {ex_ready, mem_ready}, 2'b11);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("t3_full_pending", pending, 4);
        chk("t3_full_rdy", {ex_ready, mem_ready}, 2'b00);
        ex_valid = 1'b0;
        chk("t3_wr", wr, 1);
        chk("t3_dest", dest_out, 2);
        chk("t3_data", data_out, 16'hA001);
        tick();
        wr_success = 1'b1;
        mem_valid = 1'b1;
        #1 chk("t3_no_bypass", {ex_ready, mem_ready}, 2'b00);
        tick();
        wr_success = 1'b0;
        ex_valid = 1'b1;
        #1;
        chk("t3_pending3", pending, 3);
        chk("t3_rdy_at3", {ex_ready, mem_ready}, 2'b01);
        mem_valid = 1'b0; ex_valid = 1'b0;
        #1;
        issue_ack("t3b", 3'd3, 16'hA002, 1'b1);
        issue_ack("t3c", 3'd4, 16'hA003, 1'b1);
        issue_ack("t3d", 3'd5, 16'hA004, 1'b1);
        chk("t3_drained", pending, 0);

        // one retry
        push(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h1234);
        tick();
        issue_ack("t4_try1", 3'd6, 16'h1234, 1'b0);
        issue_ack("t4_try2", 3'd6, 16'h1234, 1'b1);
        chk("t4_pending", pending, 0);
        chk("t4_err", wr_err, 0);
        tick();
        chk("t4_no_reissue", wr, 0);

        // retries exhausted
        push(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h7777);
        tick();
        issue_ack("t5_try1", 3'd7, 16'h7777, 1'b0);
        issue_ack("t5_try2", 3'd7, 16'h7777, 1'b0);
        issue_ack("t5_try3", 3'd7, 16'h7777, 1'b0);
        mem_valid = 1'b1; ex_valid = 1'b1; fwd_addr = 3'd7;
        #1;
        chk("t5_err", wr_err, 1);
        chk("t5_wr", wr, 0);
        chk("t5_rdy", {ex_ready, mem_ready}, 2'b00);
        chk("t5_pending", pending, 1);
        chk("t5_fwd", {fwd_hit, fwd_data}, {1'b1, 16'h7777});
        tick();
        tick();
        chk("t5_wr_held", wr, 0);
        chk("t5_err_sticky", wr_err, 1);
        mem_valid = 1'b0; ex_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_err", wr_err, 0);
        chk("t5_rst_pending", pending, 0);
        chk("t5_rst_out", {wr, dest_out, data_out}, 20'h0);
        tick();
        rst = 1'b0;
        tick();

        // reset during WAIT_ACK
        push(1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202);
        tick();
        chk("t6_wr", wr, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_pending", pending, 0);
        chk("t6_rst_wr", wr, 0);
        tick();
        rst = 1'b0;
        wr_success = 1'b1;
        tick();
        wr_success = 1'b0;
        #1;
        chk("t6_late_ack", {pending, wr, wr_err}, 5'h0);
        push(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h4444);
        tick();
        issue_ack("t6_new", 3'd4, 16'h4444, 1'b1);
        chk("t6_done", pending, 0);
        chk("t6_err", wr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_write_ctrl.md
# wb_write_ctrl

Writeback initiator for the general-purpose register file's single write port. Accepts ALU results and load data from the execute and memory stages, buffers them in a small in-order queue, and issues one write at a time on the regfile `wr`/`dest_in`/`data_in` port. It confirms each write with the regfile's `wr_success` response and retries unconfirmed writes. A forwarding lookup returns the youngest not-yet-committed value for any register address.

## Interface
- `DEPTH`, 4: write-queue entries (power of two, ≥2)
- `MAX_RETRY`, 3: unconfirmed issues tolerated per entry before error
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  execute-stage result valid
- `ex_dest`  in  3  execute destination register
- `ex_data`  in  16  execute result
- `ex_ready`  out  1  execute result accepted this cycle when `ex_valid`
- `mem_valid`  in  1  load result valid
- `mem_dest`  in  3  load destination register
- `mem_data`  in  16  load data
- `mem_ready`  out  1  load accepted this cycle when `mem_valid`
- `wr`  out  1  write strobe to regfile
- `dest_out`  out  3  drives regfile `dest_in`
- `data_out`  out  16  drives regfile `data_in`
- `wr_success`  in  1  regfile confirmation, valid the cycle after `wr`
- `fwd_addr`  in  3  forwarding lookup address
- `fwd_hit`  out  1  queue holds a pending write to `fwd_addr`
- `fwd_data`  out  16  youngest pending value for `fwd_addr`, 0 when no hit
- `pending`  out  $clog2(DEPTH)+1  occupied entries
- `wr_err`  out  1  sticky: an entry exhausted its retries

## Operation
- Queue: circular buffer of {dest[2:0], data[15:0]}, with head/tail pointers and a count. Entries commit in order.
- Enqueue:
  - `mem_ready` = free ≥ 1.
  - `ex_ready` = free ≥ 1 when `mem_valid`=0; free ≥ 2 when `mem_valid`=1.
  - Same-cycle acceptance of both: the mem entry is placed first (older), then the ex entry.
  - Both ready signals are 0 while in ERROR.
- FSM states: IDLE, ISSUE, WAIT_ACK, ERROR.
  - IDLE: if count > 0, go to ISSUE.
  - ISSUE: `wr`=1 with the head entry on `dest_out`/`data_out`. Go to WAIT_ACK.
  - WAIT_ACK, `wr_success`=1: pop head, clear retry count. Go to ISSUE if count after pop > 0, else IDLE.
  - WAIT_ACK, `wr_success`=0: increment retry. If retry reaches MAX_RETRY, go to ERROR; else go to ISSUE and re-issue the same entry.
  - ERROR: terminal until reset. `wr_err`=1, `wr`=0, queue frozen, forwarding still active.
- Forwarding: combinational search over all occupied entries, including the head in flight. The youngest match wins. An entry being enqueued in the current cycle is not visible.
- Count update: simultaneous pop and enqueue apply both, so count changes by (enqueued − popped).
- Pointer wrap: pointers are modulo DEPTH.

## Timing
- Reset (async): FSM=IDLE, pointers/count/retry=0, `wr`=0, `dest_out`=0, `data_out`=0, `wr_err`=0, `pending`=0. All outputs reach these values immediately on `rst`.
- `wr`, `dest_out` and `data_out` are registered. `wr` is high for exactly one cycle per issue.
- Latency: enqueue at edge N → IDLE sees count at N+1 → `wr` high in cycle N+2 → `wr_success` sampled in cycle N+3.
- Throughput: one committed write every 2 cycles.
- `ex_ready`, `mem_ready`, `fwd_*` and `pending` are combinational from registered state plus `mem_valid`/`fwd_addr`.
- Full queue: both readies are 0. A pop in the same cycle does not raise ready; there is no bypass.
- Reset during WAIT_ACK: the in-flight write is abandoned and any late `wr_success` is ignored.
- `wr_success` outside WAIT_ACK is ignored.

## Structure
- Package `wb_pkg` holds:
  - `wb_entry_t` struct {dest, data}
  - FSM state enum `wb_state_e`
  - `REG_ADDR_W`=3 and `DATA_W`=16 constants, shared with the decode stage
- One sub-module, `wb_queue`, contains the circular buffer, dual-push logic, pop, count, and the forwarding search. The FSM and retry logic stay in the top level.

## Test plan
- Single ex write: dest=3, data=0xBEEF, regfile acks. Expect `wr`=1 with dest 3 / 0xBEEF two cycles after acceptance, then `pending` goes 1→0.
- Dual push in one cycle: mem (R1=0x1111) and ex (R1=0x2222). Expect issue order 0x1111 then 0x2222; `fwd_addr`=1 returns 0x2222 until the second write is confirmed, then `fwd_hit`=0.
- Fill to DEPTH=4 with the regfile stalled. Expect `ex_ready`=`mem_ready`=0; with 3 entries plus both valid, expect `mem_ready`=1 and `ex_ready`=0.
- Withhold `wr_success` once, then ack. Expect the same entry re-issued and committed exactly once, with `wr_err`=0.
- Withhold `wr_success` 3 times. Expect `wr_err`=1, `wr` held at 0, both readies 0, `pending` unchanged; then assert `rst` and expect all outputs cleared asynchronously.
- Assert reset during WAIT_ACK with 2 entries queued. Expect `pending`=0, a `wr_success` pulse in the next cycle has no effect, and a new write afterwards completes normally.
